// File: rtl/package_decode.sv
`default_nettype none
// ============================================================================
// Package     : package_decode
// Description : Shared types and constants for the RV32I decode/issue logic.
//               Holds the issue-scheduler FSM encoding and the architectural
//               register count used by the scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package package_decode;

  // Number of architectural integer registers tracked by the scoreboard.
  localparam int SCH_NREG = 32;

  // Issue scheduler states.
  typedef enum logic [1:0] {
    SCH_RUN   = 2'b00,
    SCH_FLUSH = 2'b01,
    SCH_DRAIN = 2'b10
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register in-flight write tracker. A bit is set when the
//               writer of that register issues and cleared when it commits in
//               WB; a same-cycle set and clear of one register leaves it set.
//               Also produces the RAW/WAW hazard for the instruction in ID.
// Ports       : clk_i, rst_i             clock, async active-high reset
//               set_en_i, set_idx_i      issue of a register writer
//               clr_en_i, clr_idx_i      WB commit of a register writer
//               id_*                     operand usage of the ID instruction
//               pending_o                registered scoreboard vector
//               hazard_o                 ID instruction must not issue
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
  import package_decode::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                set_en_i,
  input  logic [4:0]          set_idx_i,
  input  logic                clr_en_i,
  input  logic [4:0]          clr_idx_i,
  input  logic                id_vld_i,
  input  logic [4:0]          id_rs1_i,
  input  logic                id_rs1_use_i,
  input  logic [4:0]          id_rs2_i,
  input  logic                id_rs2_use_i,
  input  logic [4:0]          id_rd_i,
  input  logic                id_rd_we_i,
  output logic [SCH_NREG-1:0] pending_o,
  output logic                hazard_o
);

  logic [SCH_NREG-1:0] r_pending;
  logic [SCH_NREG-1:0] w_set_vec;
  logic [SCH_NREG-1:0] w_clr_vec;
  logic [SCH_NREG-1:0] w_eff;

  // x0 is hardwired to zero, so a write to it never becomes pending.
  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    if (set_en_i && (set_idx_i != 5'd0)) begin
      w_set_vec[set_idx_i] = 1'b1;
    end
    if (clr_en_i) begin
      w_clr_vec[clr_idx_i] = 1'b1;
    end
  end

  // OR-ing the set vector after the clear makes set win on a collision.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_vec) | w_set_vec;
    end
  end

  // With a write-through regfile the value committing this cycle is already
  // readable, so its bit no longer blocks the ID instruction.
  assign w_eff = WB_BYPASS ? (r_pending & ~w_clr_vec) : r_pending;

  assign hazard_o  = id_vld_i & ((id_rs1_use_i & w_eff[id_rs1_i]) |
                                 (id_rs2_use_i & w_eff[id_rs2_i]) |
                                 (id_rd_we_i   & w_eff[id_rd_i]));
  assign pending_o = r_pending;

endmodule
`default_nettype wire

// File: rtl/pipe_sched.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sched
// Description : Issue and flush scheduler for the non-forwarding pipelined
//               RV32I core. Decides whether the IF/ID instruction enters
//               ID/EX, sequences flushes after EX redirects, drains the
//               pipeline for serialising instructions and counts stall/flush
//               events for the trace logger.
// Ports       : clk_i, rst_i             clock, async active-high reset
//               id_*                     IF/ID instruction operand info
//               ex_redirect_i            taken branch/jump resolved in EX
//               lsu_busy_i               MEM stage not complete
//               wb_vld_i/wb_we_i/wb_rd_i WB commit
//               issue_o                  ID instruction moves into ID/EX
//               stall_if_o               hold PC and IF/ID
//               bubble_idex_o            load NOP into ID/EX
//               flush_ifid_o             invalidate IF/ID
//               freeze_o                 hold PC..EX/MEM, bubble MEM/WB
//               pending_o                scoreboard
//               state_o                  FSM state
//               stall_cnt_o/flush_cnt_o  saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_sched
  import package_decode::*;
#(
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned CNT_W     = 32,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                id_vld_i,
  input  logic [4:0]          id_rs1_i,
  input  logic [4:0]          id_rs2_i,
  input  logic                id_rs1_use_i,
  input  logic                id_rs2_use_i,
  input  logic [4:0]          id_rd_i,
  input  logic                id_rd_we_i,
  input  logic                id_drain_i,
  input  logic                ex_redirect_i,
  input  logic                lsu_busy_i,
  input  logic                wb_vld_i,
  input  logic                wb_we_i,
  input  logic [4:0]          wb_rd_i,
  output logic                issue_o,
  output logic                stall_if_o,
  output logic                bubble_idex_o,
  output logic                flush_ifid_o,
  output logic                freeze_o,
  output logic [SCH_NREG-1:0] pending_o,
  output logic [1:0]          state_o,
  output logic [CNT_W-1:0]    stall_cnt_o,
  output logic [CNT_W-1:0]    flush_cnt_o
);

  localparam logic [2:0] c_flush_load = 3'(FLUSH_CYC);
  localparam bit         c_has_flush  = (FLUSH_CYC != 0);

  sched_state_e        r_state, w_state_nxt;
  logic [2:0]          r_fcnt, w_fcnt_nxt;
  logic [CNT_W-1:0]    r_stall_cnt, r_flush_cnt;
  logic [SCH_NREG-1:0] w_pending;
  logic                w_hazard;
  logic                w_redirect_acc;
  logic                w_pending_any;

  reg_scoreboard #(
    .WB_BYPASS (WB_BYPASS)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .set_en_i     (issue_o & id_rd_we_i),
    .set_idx_i    (id_rd_i),
    .clr_en_i     (wb_vld_i & wb_we_i),
    .clr_idx_i    (wb_rd_i),
    .id_vld_i     (id_vld_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs1_use_i (id_rs1_use_i),
    .id_rs2_i     (id_rs2_i),
    .id_rs2_use_i (id_rs2_use_i),
    .id_rd_i      (id_rd_i),
    .id_rd_we_i   (id_rd_we_i),
    .pending_o    (w_pending),
    .hazard_o     (w_hazard)
  );

  assign w_pending_any = |w_pending;

  always_comb begin
    issue_o        = 1'b0;
    stall_if_o     = 1'b0;
    bubble_idex_o  = 1'b0;
    flush_ifid_o   = 1'b0;
    w_redirect_acc = 1'b0;
    w_state_nxt    = r_state;
    w_fcnt_nxt     = r_fcnt;
    if (lsu_busy_i) begin
      // Whole front of the pipe is held; nothing moves, redirects wait.
      stall_if_o = 1'b1;
    end else begin
      case (r_state)
        SCH_RUN: begin
          if (ex_redirect_i) begin
            flush_ifid_o   = 1'b1;
            bubble_idex_o  = 1'b1;
            w_redirect_acc = 1'b1;
            if (c_has_flush) begin
              w_state_nxt = SCH_FLUSH;
              w_fcnt_nxt  = c_flush_load;
            end
          end else if (id_vld_i && id_drain_i && w_pending_any) begin
            stall_if_o    = 1'b1;
            bubble_idex_o = 1'b1;
            w_state_nxt   = SCH_DRAIN;
          end else if (w_hazard) begin
            stall_if_o    = 1'b1;
            bubble_idex_o = 1'b1;
          end else begin
            issue_o = id_vld_i;
          end
        end
        SCH_FLUSH: begin
          flush_ifid_o  = 1'b1;
          bubble_idex_o = 1'b1;
          w_fcnt_nxt    = r_fcnt - 3'd1;
          if (r_fcnt <= 3'd1) begin
            w_state_nxt = SCH_RUN;
          end
        end
        SCH_DRAIN: begin
          if (ex_redirect_i) begin
            flush_ifid_o   = 1'b1;
            bubble_idex_o  = 1'b1;
            w_redirect_acc = 1'b1;
            w_state_nxt    = c_has_flush ? SCH_FLUSH : SCH_RUN;
            w_fcnt_nxt     = c_flush_load;
          end else if (w_pending_any) begin
            stall_if_o    = 1'b1;
            bubble_idex_o = 1'b1;
          end else begin
            // Scoreboard is empty: the serialising instruction goes now.
            issue_o     = id_vld_i;
            w_state_nxt = SCH_RUN;
          end
        end
        default: begin
          w_state_nxt = SCH_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= SCH_RUN;
      r_fcnt  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (id_vld_i && !issue_o && !flush_ifid_o && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_redirect_acc && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign freeze_o    = lsu_busy_i;
  assign pending_o   = w_pending;
  assign state_o     = r_state;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_sched
// Description : Directed self-checking bench for pipe_sched (FLUSH_CYC=2,
//               WB_BYPASS=1). Inputs change 1 time unit after a rising edge;
//               combinational outputs are checked 1 unit later and registered
//               state is checked after the following edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_vld_i, id_rs1_use_i, id_rs2_use_i, id_rd_we_i, id_drain_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i, wb_rd_i;
  logic        ex_redirect_i, lsu_busy_i, wb_vld_i, wb_we_i;
  logic        issue_o, stall_if_o, bubble_idex_o, flush_ifid_o, freeze_o;
  logic [31:0] pending_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  int checks = 0;
  int errors = 0;

  pipe_sched #(
    .FLUSH_CYC (2),
    .CNT_W     (32),
    .WB_BYPASS (1'b1)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_vld_i      (id_vld_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_use_i  (id_rs1_use_i),
    .id_rs2_use_i  (id_rs2_use_i),
    .id_rd_i       (id_rd_i),
    .id_rd_we_i    (id_rd_we_i),
    .id_drain_i    (id_drain_i),
    .ex_redirect_i (ex_redirect_i),
    .lsu_busy_i    (lsu_busy_i),
    .wb_vld_i      (wb_vld_i),
    .wb_we_i       (wb_we_i),
    .wb_rd_i       (wb_rd_i),
    .issue_o       (issue_o),
    .stall_if_o    (stall_if_o),
    .bubble_idex_o (bubble_idex_o),
    .flush_ifid_o  (flush_ifid_o),
    .freeze_o      (freeze_o),
    .pending_o     (pending_o),
    .state_o       (state_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    id_vld_i = 1'b0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
    id_rs1_use_i = 1'b0; id_rs2_use_i = 1'b0;
    id_rd_i = 5'd0; id_rd_we_i = 1'b0; id_drain_i = 1'b0;
    ex_redirect_i = 1'b0;
    wb_vld_i = 1'b0; wb_we_i = 1'b0; wb_rd_i = 5'd0;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_vld_i = 1'b1; wb_we_i = 1'b1; wb_rd_i = rd;
  endtask

  task automatic wb_off();
    wb_vld_i = 1'b0; wb_we_i = 1'b0; wb_rd_i = 5'd0;
  endtask

  initial begin
    rst_i = 1'b1;
    lsu_busy_i = 1'b0;
    idle();
    tick(); tick();
    // Reset state
    chk("rst_pending", pending_o, 32'h0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_stall_cnt", stall_cnt_o, 32'd0);
    chk("rst_flush_cnt", flush_cnt_o, 32'd0);
    chk("rst_freeze", 32'(freeze_o), 32'd0);
    rst_i = 1'b0;

    // ---------------- RAW: addi x5 ; add x6,x5,x1 ----------------
    id_vld_i = 1'b1; id_rd_i = 5'd5; id_rd_we_i = 1'b1;
    #1 chk("raw_a_issue", 32'(issue_o), 32'd1);
    tick();
    chk("raw_pending_x5", pending_o, 32'h0000_0020);
    id_rd_i = 5'd6; id_rs1_i = 5'd5; id_rs1_use_i = 1'b1; id_rs2_i = 5'd1; id_rs2_use_i = 1'b1;
    #1 chk("raw_b_stall_issue", 32'(issue_o), 32'd0);
    chk("raw_b_stall_if", 32'(stall_if_o), 32'd1);
    chk("raw_b_bubble", 32'(bubble_idex_o), 32'd1);
    tick();
    tick();
    #1 chk("raw_b_stall3_issue", 32'(issue_o), 32'd0);
    tick();
    wb(5'd5);
    #1 chk("raw_b_issue_at_commit", 32'(issue_o), 32'd1);
    tick();
    chk("raw_pending_x6", pending_o, 32'h0000_0040);
    chk("raw_stall_cnt", stall_cnt_o, 32'd3);
    idle();
    wb(5'd6);
    tick();
    chk("raw_pending_clear", pending_o, 32'h0);

    // ---------------- WAW and set/clear collision on x7 ----------------
    idle();
    id_vld_i = 1'b1; id_rd_i = 5'd7; id_rd_we_i = 1'b1;
    #1 chk("waw_first_issue", 32'(issue_o), 32'd1);
    tick();
    chk("waw_pending", pending_o, 32'h0000_0080);
    #1 chk("waw_second_stall", 32'(stall_if_o), 32'd1);
    chk("waw_second_noissue", 32'(issue_o), 32'd0);
    tick();
    wb(5'd7);
    #1 chk("waw_second_issue", 32'(issue_o), 32'd1);
    tick();
    chk("waw_set_wins", pending_o, 32'h0000_0080);
    chk("waw_stall_cnt", stall_cnt_o, 32'd4);
    // Retire x7 while issuing a write to x0
    idle();
    wb(5'd7);
    id_vld_i = 1'b1; id_rd_i = 5'd0; id_rd_we_i = 1'b1;
    #1 chk("x0_issue", 32'(issue_o), 32'd1);
    tick();
    chk("x0_never_pending", pending_o, 32'h0);

    // ---------------- Redirect with FLUSH_CYC=2, held through FLUSH ----------------
    idle();
    id_vld_i = 1'b1; ex_redirect_i = 1'b1;
    #1 chk("redir_t_flush", 32'(flush_ifid_o), 32'd1);
    chk("redir_t_bubble", 32'(bubble_idex_o), 32'd1);
    chk("redir_t_issue", 32'(issue_o), 32'd0);
    tick();
    chk("redir_state_t1", 32'(state_o), 32'd1);
    chk("redir_flush_cnt_t1", flush_cnt_o, 32'd1);
    #1 chk("redir_t1_flush", 32'(flush_ifid_o), 32'd1);
    chk("redir_t1_issue", 32'(issue_o), 32'd0);
    tick();
    chk("redir_state_t2", 32'(state_o), 32'd1);
    #1 chk("redir_t2_flush", 32'(flush_ifid_o), 32'd1);
    tick();
    chk("redir_state_t3", 32'(state_o), 32'd0);
    chk("redir_not_recounted", flush_cnt_o, 32'd1);
    ex_redirect_i = 1'b0;
    #1 chk("redir_t3_issue", 32'(issue_o), 32'd1);
    chk("redir_t3_noflush", 32'(flush_ifid_o), 32'd0);
    tick();
    chk("redir_stall_cnt", stall_cnt_o, 32'd4);
    chk("redir_flush_cnt", flush_cnt_o, 32'd1);

    // ---------------- Drain with pending = 0x60 ----------------
    idle();
    id_vld_i = 1'b1; id_rd_i = 5'd5; id_rd_we_i = 1'b1;
    tick();
    id_rd_i = 5'd6;
    tick();
    chk("drain_setup", pending_o, 32'h0000_0060);
    idle();
    id_vld_i = 1'b1; id_drain_i = 1'b1;
    #1 chk("drain_enter_issue", 32'(issue_o), 32'd0);
    chk("drain_enter_stall", 32'(stall_if_o), 32'd1);
    tick();
    chk("drain_state", 32'(state_o), 32'd2);
    wb(5'd5);
    #1 chk("drain_wait1_stall", 32'(stall_if_o), 32'd1);
    chk("drain_wait1_issue", 32'(issue_o), 32'd0);
    tick();
    chk("drain_pending_x6", pending_o, 32'h0000_0040);
    chk("drain_state_hold", 32'(state_o), 32'd2);
    wb(5'd6);
    #1 chk("drain_wait2_issue", 32'(issue_o), 32'd0);
    tick();
    chk("drain_pending_empty", pending_o, 32'h0);
    wb_off();
    #1 chk("drain_issue", 32'(issue_o), 32'd1);
    chk("drain_issue_nostall", 32'(stall_if_o), 32'd0);
    tick();
    chk("drain_back_run", 32'(state_o), 32'd0);
    chk("drain_stall_cnt", stall_cnt_o, 32'd7);

    // ---------------- Freeze with redirect and hazard present ----------------
    idle();
    id_vld_i = 1'b1; id_rd_i = 5'd3; id_rd_we_i = 1'b1;
    tick();
    id_rd_i = 5'd9;
    tick();
    chk("frz_setup", pending_o, 32'h0000_0208);
    idle();
    id_vld_i = 1'b1; id_rs1_i = 5'd3; id_rs1_use_i = 1'b1;
    ex_redirect_i = 1'b1; lsu_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) wb(5'd3);
      else wb_off();
      #1 chk("frz_issue", 32'(issue_o), 32'd0);
      chk("frz_freeze", 32'(freeze_o), 32'd1);
      chk("frz_noflush", 32'(flush_ifid_o), 32'd0);
      tick();
      chk("frz_state_hold", 32'(state_o), 32'd0);
    end
    chk("frz_wb_cleared_x3", pending_o, 32'h0000_0200);
    chk("frz_flush_cnt_hold", flush_cnt_o, 32'd1);
    chk("frz_stall_cnt", stall_cnt_o, 32'd11);
    lsu_busy_i = 1'b0;
    #1 chk("frz_release_flush", 32'(flush_ifid_o), 32'd1);
    chk("frz_release_freeze", 32'(freeze_o), 32'd0);
    tick();
    chk("frz_redir_state", 32'(state_o), 32'd1);
    chk("frz_redir_flush_cnt", flush_cnt_o, 32'd2);
    chk("frz_redir_stall_cnt", stall_cnt_o, 32'd11);

    // ---------------- Asynchronous reset in FLUSH with pending != 0 ----------------
    #2 rst_i = 1'b1;
    #1 chk("arst_pending", pending_o, 32'h0);
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_stall_cnt", stall_cnt_o, 32'd0);
    chk("arst_flush_cnt", flush_cnt_o, 32'd0);
    idle();
    #1 rst_i = 1'b0;
    tick();
    id_vld_i = 1'b1; id_rd_i = 5'd0; id_rd_we_i = 1'b1;
    #1 chk("post_rst_issue", 32'(issue_o), 32'd1);
    tick();
    chk("post_rst_x0", pending_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_sched.md
# pipe_sched

Issue and flush scheduler for the non-forwarding pipelined RV32I core. It owns a per-register scoreboard of in-flight writes and decides each cycle whether the IF/ID instruction may enter ID/EX. It also sequences flushes after EX-stage redirects and drains the pipeline for serialising instructions. It drives the stall, flush and bubble controls of the IF/ID, ID/EX and PC registers, and exports stall/flush counters for the trace logger.

## Interface
- FLUSH_CYC, 1: extra flush cycles after a redirect, on top of the redirect cycle; covers imem latency; range 0..7.
- CNT_W, 32: width of the performance counters.
- WB_BYPASS, 1: 1 = regfile writes through in the same cycle, so a register cleared by WB this cycle is not a hazard.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- id_vld_i  in  1  IF/ID holds a valid instruction.
- id_rs1_i, id_rs2_i  in  5  source register indices.
- id_rs1_use_i, id_rs2_use_i  in  1  the source is actually read.
- id_rd_i  in  5  destination index.
- id_rd_we_i  in  1  instruction writes rd.
- id_drain_i  in  1  serialising instruction; needs an empty scoreboard.
- ex_redirect_i  in  1  taken branch/jump resolved in EX.
- lsu_busy_i  in  1  MEM stage not complete.
- wb_vld_i, wb_we_i  in  1  WB commit / commit writes rd.
- wb_rd_i  in  5  WB destination.
- issue_o  out  1  ID instruction moves into ID/EX this cycle.
- stall_if_o  out  1  hold PC and IF/ID.
- bubble_idex_o  out  1  load NOP into ID/EX.
- flush_ifid_o  out  1  invalidate IF/ID.
- freeze_o  out  1  hold PC, IF/ID, ID/EX, EX/MEM; MEM/WB takes a bubble.
- pending_o  out  32  scoreboard.
- state_o  out  2  FSM state.
- stall_cnt_o, flush_cnt_o  out  CNT_W  counters.

## Operation
- Scoreboard: bit r is set when the writer of r has issued and not yet committed. Bit 0 is never set.
  - Set on issue_o & id_rd_we_i & id_rd_i≠0.
  - Clear on wb_vld_i & wb_we_i.
  - Set and clear of the same register in one cycle: set wins.
- Effective pending (eff) = pending_o with the WB-cleared bit removed when WB_BYPASS=1; otherwise eff = pending_o.
- Hazard = id_vld_i and any of:
  - rs1 is used and eff[rs1]=1;
  - rs2 is used and eff[rs2]=1;
  - id_rd_we_i and eff[rd]=1 (WAW stall).
- Freeze = lsu_busy_i. While frozen: issue_o=0, FSM holds, ex_redirect_i is ignored. WB still clears the scoreboard.
- FSM RUN:
  - Redirect (not frozen): flush_ifid_o=1, bubble_idex_o=1, issue_o=0. Go to FLUSH if FLUSH_CYC>0, loading cnt=FLUSH_CYC.
  - Else if id_vld & id_drain & pending_o≠0: go to DRAIN, stall.
  - Else if hazard: stall_if_o=1, bubble_idex_o=1.
  - Else: issue_o=id_vld_i.
- FSM FLUSH:
  - flush_ifid_o=1, bubble_idex_o=1, issue_o=0. Decrement cnt; go to RUN after the cycle with cnt=1.
  - ex_redirect_i is ignored.
- FSM DRAIN:
  - stall_if_o=1, bubble_idex_o=1 until pending_o==0. In that cycle issue_o=1 (if no redirect), then go to RUN.
  - Redirect in DRAIN: flush as in RUN, go to FLUSH (or RUN if FLUSH_CYC=0).
- stall_cnt_o increments on every cycle with id_vld_i & !issue_o & !flush_ifid_o. flush_cnt_o increments once per accepted redirect. Both saturate at all-ones.

## Timing
- issue_o, stall_if_o, bubble_idex_o, flush_ifid_o and freeze_o are combinational from the current state and inputs. The scoreboard, FSM and counters update on posedge clk_i.
- Instruction A writes x5 and B reads x5: B issues in the cycle A's WB commits when WB_BYPASS=1, or one cycle later when WB_BYPASS=0.
- Redirect sampled in cycle t: IF/ID is invalidated in cycles t..t+FLUSH_CYC; the first issue is possible at t+FLUSH_CYC+1.
- Reset (asynchronous, any state): pending_o=0, state RUN, FLUSH count 0, both counters 0.
  - Combinational outputs follow from that state: freeze_o=lsu_busy_i, other outputs driven by inputs as in RUN.

## Structure
- Add to package_decode:
  - sched_state_e: SCH_RUN=2'b00, SCH_FLUSH=2'b01, SCH_DRAIN=2'b10.
  - Constant SCH_NREG=32.
- Sub-module reg_scoreboard holds the 32-bit set/clear vector, the eff logic and the hazard compare. pipe_sched contains the FSM, flush counter and performance counters.

## Test plan
- RAW: issue `addi x5`, then `add x6,x5,x1` next cycle. B stalls until x5 commits in WB; with WB_BYPASS=1, B issues in the commit cycle; stall_cnt_o=3 for the 5-stage depth.
- WAW plus set/clear collision: two writers to x7 back to back. The second stalls until the first commits. When the second issues in the same cycle the first commits, pending_o[7]=1.
- Redirect with FLUSH_CYC=2: ex_redirect_i pulsed at t. flush_ifid_o is high at t, t+1, t+2; state_o is FLUSH for 2 cycles; flush_cnt_o=1. A redirect held through FLUSH is not recounted.
- Drain: id_drain_i while pending_o=0x0000_0060. The FSM enters DRAIN, then issues in the cycle pending_o reaches 0, then returns to RUN.
- Freeze: lsu_busy_i high for 4 cycles while a redirect and a hazard are present. issue_o=0 and the FSM holds; WB clears x3 during the freeze; the redirect is acted on in the first unfrozen cycle.
- Asynchronous reset in FLUSH with pending_o≠0: all state is cleared immediately, without waiting for a clock edge. x0 writes never set bit 0.
